// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the one-hot state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned STATE_W        = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_count,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; reset value chosen so the output looks idle after reset
  always_ff @(posedge clk or negedge rst_count) begin
    if (!rst_count) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, mid-bit sampling, one-cycle done/error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_count,
  input  logic                 baud_rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  // DATA_BITS is expected to be at least 2 (bit counter and shift slice)
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_e           state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  rx_s;

  // Bring the asynchronous line into the clk domain, idle-high after reset
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk       (clk),
    .rst_count (rst_count),
    .d         (rx),
    .q         (rx_s)
  );

  // Receive FSM: start detect, mid-start qualify, data shift, stop check
  always_ff @(posedge clk or negedge rst_count) begin
    if (!rst_count) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      d_out     <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_rate) begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                // Line went back high before mid start bit: treat as a glitch
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (baud_rate) begin
            if (tick_cnt == TICK_LAST) begin
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (baud_rate) begin
            if (tick_cnt == TICK_LAST) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed
              tick_cnt <= '0;
              state    <= ST_IDLE;
              busy     <= 1'b0;
              if (rx_s) begin
                d_out   <= shift;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitch, bad stop, reset mid-frame, loopback.
module tb_uart_rx;

  logic       clk;
  logic       rst_count;
  logic       baud_rate;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int n_run  = 0;
  int n_fail = 0;

  int cyc     = 0;
  int div_max = 4;
  int div_cnt = 0;
  int bit_clks;
  int err_cnt = 0;
  int fall_cyc;

  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst_count (rst_count),
    .baud_rate (baud_rate),
    .rx        (rx),
    .d_out     (d_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Baud enable: one tick every div_max clocks, changed on the falling edge
  initial begin
    baud_rate = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt   = (div_cnt + 1 >= div_max) ? 0 : div_cnt + 1;
      baud_rate = (div_cnt == 0);
    end
  end

  // Record every output pulse, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done) begin
      got.push_back(d_out);
      got_cyc.push_back(cyc);
    end
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_run++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one 8N1 frame; stop level and stop length are selectable
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_clks);
    rx = 1'b0;
    fall_cyc = cyc;
    idle(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(bit_clks);
    end
    rx = stop_lvl;
    idle(stop_clks);
    rx = 1'b1;
  endtask

  initial begin
    int n0, e0, first_fall;
    rx        = 1'b1;
    rst_count = 1'b0;
    bit_clks  = 16 * div_max;
    idle(3);

    // Reset state
    chk("rst_d_out", 32'(d_out), 32'h0);
    chk("rst_rx_done", 32'(rx_done), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_count = 1'b1;
    idle(10);
    chk("idle_no_start", 32'(busy), 32'h0);

    // Single frame 0xA5 with latency check
    send_frame(8'hA5, 1'b1, bit_clks);
    idle(8);
    chk("a5_count", 32'(got.size()), 32'd1);
    chk("a5_byte", 32'(got[0]), 32'hA5);
    chk("a5_d_out", 32'(d_out), 32'hA5);
    chk("a5_err", 32'(err_cnt), 32'd0);
    chk("a5_busy", 32'(busy), 32'h0);
    chk_rng("a5_latency", got_cyc[0] - fall_cyc, 606, 613);

    // Back-to-back 0x00 then 0xFF, no idle gap
    idle(20);
    send_frame(8'h00, 1'b1, bit_clks);
    first_fall = fall_cyc;
    send_frame(8'hFF, 1'b1, bit_clks);
    idle(8);
    chk("b2b_count", 32'(got.size()), 32'd3);
    chk("b2b_first", 32'(got[1]), 32'h00);
    chk("b2b_second", 32'(got[2]), 32'hFF);
    chk_rng("b2b_spacing", got_cyc[2] - got_cyc[1], 636, 644);
    chk_rng("b2b_fall_gap", fall_cyc - first_fall, 640, 640);
    chk("b2b_err", 32'(err_cnt), 32'd0);

    // Short low glitch of 5 ticks: rejected at the mid-start check
    idle(20);
    rx = 1'b0;
    idle(12);
    chk("glitch_busy", 32'(busy), 32'h1);
    idle(8);
    rx = 1'b1;
    idle(200);
    chk("glitch_count", 32'(got.size()), 32'd3);
    chk("glitch_err", 32'(err_cnt), 32'd0);
    chk("glitch_d_out", 32'(d_out), 32'hFF);
    chk("glitch_busy_after", 32'(busy), 32'h0);

    // Frame 0x3C with stop bit low (line released shortly after mid stop)
    send_frame(8'h3C, 1'b0, 40);
    idle(300);
    chk("badstop_err", 32'(err_cnt), 32'd1);
    chk("badstop_count", 32'(got.size()), 32'd3);
    chk("badstop_d_out", 32'(d_out), 32'hFF);
    chk("badstop_busy", 32'(busy), 32'h0);

    // Reset in the middle of data bit 4 of a 0x55 frame
    n0 = got.size();
    e0 = err_cnt;
    rx = 1'b0;
    idle(bit_clks);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(bit_clks);
    end
    rx = 1'b1;
    idle(bit_clks / 2);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_count = 1'b0;
    #1;
    chk("midrst_d_out", 32'(d_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rx_done", 32'(rx_done), 32'h0);
    idle(3);
    rst_count = 1'b1;
    rx = 1'b1;
    idle(700);
    chk("midrst_no_pulse", 32'(got.size() - n0), 32'd0);
    chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h81, 1'b1, bit_clks);
    idle(8);
    chk("post_rst_count", 32'(got.size() - n0), 32'd1);
    chk("post_rst_d_out", 32'(d_out), 32'h81);

    // Loopback of 256 random bytes at one tick per clock
    div_max  = 1;
    bit_clks = 16;
    idle(40);
    n0 = got.size();
    e0 = err_cnt;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, bit_clks);
    end
    idle(40);
    chk("loop_count", 32'(got.size() - n0), 32'd256);
    chk("loop_err", 32'(err_cnt - e0), 32'd0);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("loop_byte_%0d", i), 32'(got[n0 + i]), 32'(exp_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
